button_toggle: RTL and testbench

- Input-side counterpart to the LED output path: reads two raw, bouncy, active-low push buttons and produces the clean, latched active-high red_en/green_en enables consumed by the LED PWM logic.
- Per channel: 2-flop synchronizer, debounce state machine, press-edge pulse, toggle latch.
- Channels are fully independent; one clock domain.

---
 rtl/button_toggle.sv | 155 +++++++++++++++
 tb/tb_button_toggle.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_toggle.sv
// Two-channel push-button front end: sync, debounce, press pulse and toggle latch.
// Define BUTTON_TOGGLE_LONG_PRESS_EN to add the long-press detector and clear.
module button_toggle #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int CNT_W           = 14
`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
  ,
  parameter int LONG_CYCLES     = 24000000,
  parameter int LONG_W          = 25
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_n,
  output logic       red_en,
  output logic       green_en,
`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
  output logic [1:0] long_press,
`endif
  output logic [1:0] press
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       s1_q, s2_q, pressed_sync;
  state_t           state_q [2];
  state_t           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       en_q, en_d, press_q, press_d;

  assign pressed_sync = ~s2_q;

`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] HOLD_SAT  = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] HOLD_ONE  = LONG_W'(1);

  logic [LONG_W-1:0] hold_q [2];
  logic [LONG_W-1:0] hold_d [2];
  logic [1:0]        long_q, long_d;
`endif

  always_comb begin
    en_d = en_q;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      press_d[i] = 1'b0;
      case (state_q[i])
        RELEASED: begin
          if (pressed_sync[i]) begin
            state_d[i] = PRESS_PEND;
            cnt_d[i]   = CNT_ONE;
          end
        end
        PRESS_PEND: begin
          if (!pressed_sync[i]) begin
            state_d[i] = RELEASED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!pressed_sync[i]) begin
            state_d[i] = RELEASE_PEND;
            cnt_d[i]   = CNT_ONE;
          end
        end
        RELEASE_PEND: begin
          if (pressed_sync[i]) begin
            state_d[i] = PRESSED;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = RELEASED;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: state_d[i] = RELEASED;
      endcase
    end
    en_d = en_q ^ press_d;

`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
    // Hold counter only advances in PRESSED, so it pauses across release bounces.
    long_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      hold_d[i] = hold_q[i];
      if (state_d[i] == RELEASED) begin
        hold_d[i] = '0;
      end else if (state_q[i] == PRESSED && pressed_sync[i]) begin
        if (hold_q[i] == HOLD_LAST) begin
          long_d[i] = 1'b1;
          hold_d[i] = HOLD_SAT;
        end else if (hold_q[i] < HOLD_LAST) begin
          hold_d[i] = hold_q[i] + HOLD_ONE;
        end
      end
    end
    if (|long_d) en_d = 2'b00;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q    <= 2'b11;
      s2_q    <= 2'b11;
      en_q    <= 2'b00;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q    <= btn_n;
      s2_q    <= s1_q;
      en_q    <= en_d;
      press_q <= press_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      long_q <= 2'b00;
      for (int i = 0; i < 2; i++) hold_q[i] <= '0;
    end else begin
      long_q <= long_d;
      for (int i = 0; i < 2; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign long_press = long_q;
`endif

  assign red_en   = en_q[0];
  assign green_en = en_q[1];
  assign press    = press_q;

endmodule

// File: tb/tb_button_toggle.sv
// Self-checking bench for button_toggle: directed scenarios plus random button traffic
// compared against a run-length debounce model.
module tb_button_toggle;
  localparam int D = 4;
  localparam int L = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_n;
  logic       red_en, green_en;
  logic [1:0] press;
`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
  logic [1:0] long_press;
`endif

  always #5 clk = ~clk;

  button_toggle #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
    ,
    .LONG_CYCLES(L),
    .LONG_W(5)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .red_en(red_en),
    .green_en(green_en),
`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
    .long_press(long_press),
`endif
    .press(press)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: accepted level per channel flips after D consecutive disagreeing
  // synchronized samples; any agreeing sample resets the run.
  logic [1:0] m_s1, m_s2, m_acc, m_en, m_press, m_long;
  int         m_run  [2];
  int         m_hold [2];
  int         npress [2];
  int         nlong  [2];

  task automatic model(input logic [1:0] b, input logic r);
    logic ps, acc_pre;
    int   run_pre;
    if (!r) begin
      m_s1 = 2'b11; m_s2 = 2'b11; m_acc = 2'b00; m_en = 2'b00;
      m_press = 2'b00; m_long = 2'b00;
      for (int i = 0; i < 2; i++) begin m_run[i] = 0; m_hold[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        ps      = ~m_s2[i];
        acc_pre = m_acc[i];
        run_pre = m_run[i];
        m_press[i] = 1'b0;
        m_long[i]  = 1'b0;
        if (ps != acc_pre) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_acc[i]   = ps;
            m_run[i]   = 0;
            m_press[i] = ps;
          end
        end else begin
          m_run[i] = 0;
        end
        if (!m_acc[i]) m_hold[i] = 0;
        else if (acc_pre && run_pre == 0 && ps) begin
          if (m_hold[i] == L - 1) begin
            m_long[i] = 1'b1;
            m_hold[i] = L;
          end else if (m_hold[i] < L - 1) begin
            m_hold[i]++;
          end
        end
      end
      m_en = m_en ^ m_press;
`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
      if (|m_long) m_en = 2'b00;
`endif
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic cycle(input logic [1:0] b, input logic r);
    btn_n = b;
    reset = r;
    @(posedge clk);
    model(b, r);
    #1;
    chk("red_en", 32'(red_en), 32'(m_en[0]));
    chk("green_en", 32'(green_en), 32'(m_en[1]));
    chk("press", 32'(press), 32'(m_press));
    npress[0] += int'(press[0]);
    npress[1] += int'(press[1]);
`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
    chk("long_press", 32'(long_press), 32'(m_long));
    nlong[0] += int'(long_press[0]);
    nlong[1] += int'(long_press[1]);
`endif
  endtask

  task automatic clear_counts();
    npress[0] = 0; npress[1] = 0; nlong[0] = 0; nlong[1] = 0;
  endtask

  initial begin
    logic [1:0] b;
    logic       r;
    int         len;
    clear_counts();

    // reset with buttons held, then release idle
    repeat (3) cycle(2'b00, 1'b0);
    chk("rst_red", 32'(red_en), 32'd0);
    chk("rst_press", 32'(press), 32'd0);
    repeat (6) cycle(2'b11, 1'b1);
    chk("idle_green", 32'(green_en), 32'd0);
    chk("idle_press_cnt", 32'(npress[0] + npress[1]), 32'd0);

    // clean red press: pulse exactly after edge 6
    clear_counts();
    for (int k = 1; k <= 8; k++) begin
      cycle(2'b10, 1'b1);
      chk("press0_lat", 32'(press[0]), 32'(k == D + 2));
      if (k == D + 1) chk("red_before", 32'(red_en), 32'd0);
    end
    chk("red_on", 32'(red_en), 32'd1);
    repeat (8) cycle(2'b11, 1'b1);
    chk("red_hold_after_rel", 32'(red_en), 32'd1);
    repeat (8) cycle(2'b10, 1'b1);
    repeat (8) cycle(2'b11, 1'b1);
    chk("red_off", 32'(red_en), 32'd0);
    chk("press0_cnt", 32'(npress[0]), 32'd2);
    chk("press1_none", 32'(npress[1]), 32'd0);

    // bounce: 3 low, 1 high, 2 low, high -> nothing accepted
    clear_counts();
    repeat (3) cycle(2'b10, 1'b1);
    cycle(2'b11, 1'b1);
    repeat (2) cycle(2'b10, 1'b1);
    repeat (8) cycle(2'b11, 1'b1);
    chk("bounce_cnt", 32'(npress[0]), 32'd0);
    chk("bounce_red", 32'(red_en), 32'd0);
    repeat (D + 2) cycle(2'b10, 1'b1);
    chk("bounce_then_press", 32'(npress[0]), 32'd1);
    repeat (6) cycle(2'b10, 1'b1);
    chk("held_no_repeat", 32'(npress[0]), 32'd1);
    repeat (8) cycle(2'b11, 1'b1);

    // simultaneous press, then a 2-cycle release glitch
    clear_counts();
    for (int k = 1; k <= 8; k++) begin
      cycle(2'b00, 1'b1);
      chk("press_both_lat", 32'(press), (k == D + 2) ? 32'd3 : 32'd0);
    end
    chk("red_toggled", 32'(red_en), 32'd0);
    chk("green_on", 32'(green_en), 32'd1);
    repeat (2) cycle(2'b11, 1'b1);
    repeat (8) cycle(2'b00, 1'b1);
    chk("glitch_no_pulse", 32'(npress[0] + npress[1]), 32'd2);
    repeat (8) cycle(2'b11, 1'b1);

    // reset during PRESS_PEND (cnt=2) with red still held
    repeat (4) cycle(2'b10, 1'b1);
    cycle(2'b10, 1'b0);
    chk("rst_mid_red", 32'(red_en), 32'd0);
    chk("rst_mid_green", 32'(green_en), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      cycle(2'b10, 1'b1);
      chk("press_after_rst", 32'(press[0]), 32'(k == D + 2));
    end
    repeat (8) cycle(2'b11, 1'b1);

`ifdef BUTTON_TOGGLE_LONG_PRESS_EN
    // long press on green clears both enables once
    repeat (D + 2) cycle(2'b00, 1'b1);
    repeat (8) cycle(2'b11, 1'b1);
    chk("both_on_r", 32'(red_en), 32'd1);
    chk("both_on_g", 32'(green_en), 32'd1);
    clear_counts();
    for (int k = 1; k <= 30; k++) begin
      cycle(2'b01, 1'b1);
      chk("long1_lat", 32'(long_press[1]), 32'(k == D + 2 + L));
    end
    chk("long_cnt", 32'(nlong[1]), 32'd1);
    chk("long_clr_r", 32'(red_en), 32'd0);
    chk("long_clr_g", 32'(green_en), 32'd0);
    repeat (8) cycle(2'b11, 1'b1);
`endif

    // random traffic
    for (int s = 0; s < 120; s++) begin
      b   = 2'($urandom_range(0, 3));
      r   = ($urandom_range(0, 29) != 0);
      len = ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(1, 7));
      repeat (len) cycle(b, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
